uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8-bit/115200 transmitter. Configurable data width, parity mode and stop-bit count. Adds a valid/ready input handshake backed by a small TX FIFO, so the host can queue several characters. Frames go out back-to-back with no idle gap. Sits between a host/bus-side producer and the serial TX pin.

Parameters:
EXTERNAL_CLOCK, 50_000_000, input clock frequency in Hz
BAUD_RATE, 115_200, line rate in baud; CLKS_PER_BIT = EXTERNAL_CLOCK / BAUD_RATE (integer division, must be >= 2)
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 1, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 4, TX FIFO entries, power of two, >= 2

Ports:
clk  in  1  system clock, all logic on rising edge
sync_reset  in  1  synchronous, active-high reset
data_in  in  DATA_BITS  character to queue
data_valid  in  1  data_in is valid
data_ready  out  1  FIFO can accept a word (= not full)
data_out  out  1  serial TX line, idle high
busy  out  1  frame in progress or FIFO non-empty
fifo_level  out  $clog2(FIFO_DEPTH+1)  occupied FIFO entries

Behaviour:
- Reset (clk edge with sync_reset=1): data_out=1, busy=0, fifo_level=0, data_ready=1. FSM goes to IDLE, bit/baud counters clear, FIFO is flushed. Reset mid-frame aborts the frame; line is high from the next edge.
- Handshake: a push occurs on an edge with data_valid && data_ready. When data_ready=0, data_valid is ignored and nothing is written or lost internally. data_ready = (fifo_level != FIFO_DEPTH), combinational from the registered level.
- Simultaneous push and pop in one cycle: level unchanged, both take effect. A push when full is impossible by construction.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: data_out=1. On an edge with FIFO non-empty, pop the head into the shift register, compute parity, enter START.
- Latency: a word pushed into an empty FIFO at edge N gets popped at edge N+1. data_out=0 from edge N+1.
- Every bit is held exactly CLKS_PER_BIT cycles; a baud counter counts 0..CLKS_PER_BIT-1.
- START: data_out=0, then DATA.
- DATA: DATA_BITS bits, LSB first; bit index 0..DATA_BITS-1. Then PARITY if PARITY != 0, else STOP.
- PARITY: even = XOR of the data bits; odd = its inverse.
- STOP: data_out=1 for STOP_BITS * CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle cycles); otherwise go to IDLE.
- The transmitted word is latched at pop. The FIFO may be refilled during a frame without corrupting it.
- data_out is driven from a flop (glitch-free). busy = (state != IDLE) || (fifo_level != 0).
- FIFO pointers wrap modulo FIFO_DEPTH. Level counter saturation is impossible by construction.

Test Plan:
All scenarios use EXTERNAL_CLOCK=16, BAUD_RATE=4 (CLKS_PER_BIT=4), FIFO_DEPTH=4 unless stated.
1. Defaults (8 bits, even parity, 1 stop): push 8'hBD -> line sampled mid-bit reads 0,1,0,1,1,1,1,0,1,0,1 (start, data LSB first, parity 0, stop). Frame is 44 clocks, start begins one edge after the push. Then idle high and busy=0.
2. PARITY=2: push 8'hBD -> parity bit 1; all other bits as in scenario 1.
3. DATA_BITS=7, PARITY=0, STOP_BITS=2: push 7'h55 -> 0, 1,0,1,0,1,0,1, 1,1. Frame is 40 clocks.
4. FIFO full/back-to-back: hold data_valid with 8'h01..8'h06 at one word per accepted cycle. Checks:
   - data_ready drops after the 5th accepted word (1 in flight + 4 queued); fifo_level=4.
   - Word 6 is accepted only after the next pop.
   - All six frames go out in order with zero idle cycles between stop and start.
   - busy falls only after the 6th stop bit.
5. Reset mid-frame: push 8'hFF, assert sync_reset at clock 10 of the frame. Checks:
   - data_out=1 and fifo_level=0 from the next edge.
   - No further frame goes out; a push after reset transmits cleanly.
6. Simultaneous push/pop: FIFO holds 1 word while IDLE; push a new word on the pop edge -> fifo_level stays 1 and both words are transmitted in order.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Parametrised UART transmitter with a small TX FIFO in front of it.
//   The host queues characters over a valid/ready handshake; queued
//   characters are sent back-to-back (start, data LSB first, optional
//   parity, 1 or 2 stop bits) with no idle gap between frames.
//
// Ports
//   clk         system clock, rising edge
//   sync_reset  synchronous active-high reset
//   data_in     character to queue (DATA_BITS wide)
//   data_valid  data_in is valid
//   data_ready  FIFO can accept a word (not full)
//   data_out    serial TX line, idle high, driven from a flop
//   busy        frame in progress or FIFO non-empty
//   fifo_level  number of occupied FIFO entries
//
// Parameter legality: CLKS_PER_BIT >= 2, DATA_BITS 5..9, PARITY 0/1/2
// (none/even/odd), STOP_BITS 1..2, FIFO_DEPTH a power of two >= 2.
module uart_tx_fifo #(
  parameter int EXTERNAL_CLOCK = 50_000_000,
  parameter int BAUD_RATE      = 115_200,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 1,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                               clk,
  input  logic                               sync_reset,
  input  logic [DATA_BITS-1:0]               data_in,
  input  logic                               data_valid,
  output logic                               data_ready,
  output logic                               data_out,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int CLKS_PER_BIT = EXTERNAL_CLOCK / BAUD_RATE;
  localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
  // One counter times both ordinary bits and the (possibly double) stop period.
  localparam int CNT_W        = $clog2(STOP_CLKS + 1);
  localparam int BIT_W        = $clog2(DATA_BITS);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int LVL_W        = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_CLKS - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Parity bit for a character: even = XOR of data bits, odd = its inverse.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    logic p;
    p = ^d;
    return (PARITY == 2) ? ~p : p;
  endfunction

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
  logic [LVL_W-1:0]     level_r;

  state_t               state_r, state_s;
  logic [CNT_W-1:0]     baud_r, baud_s;
  logic [BIT_W-1:0]     bit_r, bit_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic                 par_r, par_s;
  logic                 tx_r, tx_s;

  logic                 push_s, pop_s;
  logic [DATA_BITS-1:0] head_s;

  assign data_ready = (level_r != FULL_LVL);
  assign push_s     = data_valid && data_ready;
  assign head_s     = mem_r[rd_ptr_r];
  assign data_out   = tx_r;
  assign fifo_level = level_r;
  assign busy       = (state_r != ST_IDLE) || (level_r != '0);

  // FIFO storage: no reset needed, validity is tracked by the level counter.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // FIFO pointers and level; pointers wrap naturally since depth is 2^n.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Transmitter state, counters and the registered line value.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_r <= ST_IDLE;
      baud_r  <= '0;
      bit_r   <= '0;
      shift_r <= '0;
      par_r   <= 1'b0;
      tx_r    <= 1'b1;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      par_r   <= par_s;
      tx_r    <= tx_s;
    end
  end

  // Next-state logic. tx_s is the value the line takes from the next edge,
  // so every transition also selects the first value of the new bit.
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    par_s   = par_r;
    tx_s    = tx_r;
    pop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (level_r != '0) begin
          pop_s   = 1'b1;
          shift_s = head_s;
          par_s   = calc_parity(head_s);
          baud_s  = '0;
          bit_s   = '0;
          tx_s    = 1'b0;
          state_s = ST_START;
        end else begin
          tx_s    = 1'b1;
        end
      end
      ST_START: begin
        if (baud_r == BIT_END) begin
          baud_s  = '0;
          bit_s   = '0;
          tx_s    = shift_r[0];
          state_s = ST_DATA;
        end else begin
          baud_s  = baud_r + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_r == BIT_END) begin
          baud_s = '0;
          if (bit_r == LAST_BIT) begin
            if (PARITY != 0) begin
              tx_s    = par_r;
              state_s = ST_PARITY;
            end else begin
              tx_s    = 1'b1;
              state_s = ST_STOP;
            end
          end else begin
            bit_s   = bit_r + BIT_W'(1);
            shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
            tx_s    = shift_r[1];
          end
        end else begin
          baud_s = baud_r + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        if (baud_r == BIT_END) begin
          baud_s  = '0;
          tx_s    = 1'b1;
          state_s = ST_STOP;
        end else begin
          baud_s  = baud_r + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_r == STOP_END) begin
          baud_s = '0;
          // A queued word starts immediately: no idle cycle between frames.
          if (level_r != '0) begin
            pop_s   = 1'b1;
            shift_s = head_s;
            par_s   = calc_parity(head_s);
            bit_s   = '0;
            tx_s    = 1'b0;
            state_s = ST_START;
          end else begin
            tx_s    = 1'b1;
            state_s = ST_IDLE;
          end
        end else begin
          baud_s = baud_r + CNT_W'(1);
        end
      end
      default: begin
        tx_s    = 1'b1;
        state_s = ST_IDLE;
      end
    endcase
  end

endmodule
